// File: rtl/dmg_bus_pkg.sv
// Shared bus definitions: machine-cycle T-states and the captured request record.
package dmg_bus_pkg;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_T1,
        TS_T2,
        TS_T3,
        TS_T4
    } bus_tstate_e;

    localparam int BUS_TSTATES = 4;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

    // True while a machine cycle is in progress (T1..T4).
    function automatic logic tstate_active(input bus_tstate_e s);
        return (s != TS_IDLE);
    endfunction

endpackage

// File: rtl/bus_tstate_seq.sv
// T-state sequencer: walks IDLE->T1..T4 and decides when a new request may be taken.
module bus_tstate_seq
    import dmg_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        bus_hold,
    output bus_tstate_e state,
    output logic        req_ready,
    output logic        accept,
    output logic        busy
);

    bus_tstate_e state_next;

    // A new access may begin from IDLE or straight out of T4, unless the bus is held.
    assign req_ready = ((state == TS_IDLE) || (state == TS_T4)) && !bus_hold && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = tstate_active(state);

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= TS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: T1..T3 always advance; IDLE and T4 branch on accept.
    always_comb begin
        state_next = state;
        case (state)
            TS_IDLE: state_next = accept ? TS_T1 : TS_IDLE;
            TS_T1:   state_next = TS_T2;
            TS_T2:   state_next = TS_T3;
            TS_T3:   state_next = TS_T4;
            TS_T4:   state_next = accept ? TS_T1 : TS_IDLE;
            default: state_next = TS_IDLE;
        endcase
    end

endmodule

// File: rtl/cpu_bus_seq.sv
// CPU-side bus initiator: one 4-T-state machine cycle per byte request, with read
// data and a completion pulse returned to the core model.
module cpu_bus_seq
    import dmg_bus_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR = 16'h0000,
    parameter logic [7:0]  FLOAT_DATA = 8'hFF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        bus_hold,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [15:0] a,
    inout  wire  [7:0]  d,
    output logic        cpu_raw_rd,
    output logic        cpu_wr_sync
);

    bus_tstate_e state;
    logic        accept;
    bus_req_t    cap;
    logic        drive_d;
    logic [7:0]  sampled_d;

    bus_tstate_seq u_seq (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .bus_hold  (bus_hold),
        .state     (state),
        .req_ready (req_ready),
        .accept    (accept),
        .busy      (busy)
    );

    // Capture the request on accept; the address doubles as the held bus address in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap <= '{wr: 1'b0, addr: RESET_ADDR, wdata: 8'h00};
        end else if (accept) begin
            cap <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
        end
    end

    // Bus outputs are decoded from flops only so the decoder never sees glitches.
    assign a           = cap.addr;
    assign cpu_raw_rd  = !cap.wr && tstate_active(state);
    assign cpu_wr_sync = cap.wr && (state == TS_T3);
    assign drive_d     = cap.wr && ((state == TS_T2) || (state == TS_T3) || (state == TS_T4));
    assign d           = drive_d ? cap.wdata : 8'hzz;

    // Resolve each data bit: a firm 0 or 1 passes, anything floating takes FLOAT_DATA.
    always_comb begin
        sampled_d = FLOAT_DATA;
        for (int i = 0; i < 8; i++) begin
            if (d[i] === 1'b0) begin
                sampled_d[i] = 1'b0;
            end else if (d[i] === 1'b1) begin
                sampled_d[i] = 1'b1;
            end
        end
    end

    // Completion: pulse after T4, report type, and latch read data on reads only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            rsp_valid <= (state == TS_T4);
            if (state == TS_T4) begin
                rsp_wr <= cap.wr;
                if (!cap.wr) begin
                    rsp_rdata <= sampled_d;
                end
            end
        end
    end

endmodule
